// File: rtl/bus_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter: sizes, state
// encoding and the winner-selection helpers used by the arbiter top.
package bus_arbiter8_pkg;

   localparam int NREQ  = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // First set bit of mask, scanning p, p+1, ..., wrapping modulo NREQ.
   function automatic logic [SEL_W-1:0] pick(input logic [NREQ-1:0] mask,
                                             input logic [SEL_W-1:0] p);
      logic [SEL_W-1:0] idx;
      logic             found;
      pick  = p;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = p + SEL_W'(i);
         if (!found && mask[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] sel);
      onehot = NREQ'(1) << sel;
   endfunction

endpackage

// File: rtl/bus_arbiter8_mux8.sv
// Plain 8:1 word multiplexer driving the shared destination bus.
module mux8 #(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       select,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   input  logic [WIDTH-1:0] in5,
   input  logic [WIDTH-1:0] in6,
   input  logic [WIDTH-1:0] in7,
   output logic [WIDTH-1:0] muxout
);

   // NOTE: the default assignment ahead of the case keeps every path driven, so no latch is inferred.
   always_comb begin
      muxout = in0;
      case (select)
         3'd1:    muxout = in1;
         3'd2:    muxout = in2;
         3'd3:    muxout = in3;
         3'd4:    muxout = in4;
         3'd5:    muxout = in5;
         3'd6:    muxout = in6;
         3'd7:    muxout = in7;
         default: muxout = in0;
      endcase
   end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter sharing one WIDTH-bit bus between 8 requesters, with a
// valid/ready handshake toward the sink and a sticky withdrawal error flag.
module bus_arbiter8
   import bus_arbiter8_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       req,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   input  logic [WIDTH-1:0] in5,
   input  logic [WIDTH-1:0] in6,
   input  logic [WIDTH-1:0] in7,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_sel,
   output logic [7:0]       ack,
   output logic             err
);

   arb_state_t       state;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] next_sel;
   logic [NREQ-1:0]  remain;
   logic             accept;

   assign out_valid = (state == ARB_BUSY);
   assign accept    = out_valid & out_ready;
   assign ack       = accept ? onehot(out_sel) : '0;
   assign next_sel  = out_sel + SEL_W'(1);
   // Requests still pending once the current word leaves; drives back-to-back grants.
   assign remain    = req & ~onehot(out_sel);

   mux8 #(.WIDTH(WIDTH)) u_mux8 (
      .select (out_sel),
      .in0    (in0),
      .in1    (in1),
      .in2    (in2),
      .in3    (in3),
      .in4    (in4),
      .in5    (in5),
      .in6    (in6),
      .in7    (in7),
      .muxout (out_data)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ARB_IDLE;
         out_sel <= '0;
         ptr     <= '0;
         err     <= 1'b0;
      end else begin
         // A granted requester must hold req until its word is taken.
         if (state == ARB_BUSY && !req[out_sel] && !accept)
            err <= 1'b1;

         case (state)
            ARB_IDLE: begin
               if (req != '0) begin
                  out_sel <= pick(req, ptr);
                  state   <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (accept) begin
                  ptr <= next_sel;
                  if (remain != '0)
                     out_sel <= pick(remain, next_sel);
                  else
                     state <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
